// File: rtl/bcd_operand_adder.sv
// bcd_operand_adder: captures two successive BCD numbers from the input
// manager as operands A and B, then adds them one digit per clock with a
// ripple carry.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-low reset
//   number_in    BCD number, digit i at [4i+3:4i]
//   number_valid input-manager ready level; only its 0->1 edge is an event
//   clear        synchronous abort/restart, active-high
//   operand_a/b  captured operands
//   sum_bcd      BCD sum, top digit 0 or 1
//   sum_valid    sum_bcd holds a completed result
//   busy         addition in progress
//   error        last captured number had a digit > 9
//   state_out    0 WAIT_A, 1 WAIT_B, 2 ADD, 3 DONE
module bcd_operand_adder #(
  parameter int unsigned DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*DIGITS-1:0]     number_in,
  input  logic                    number_valid,
  input  logic                    clear,
  output logic [4*DIGITS-1:0]     operand_a,
  output logic [4*DIGITS-1:0]     operand_b,
  output logic [4*(DIGITS+1)-1:0] sum_bcd,
  output logic                    sum_valid,
  output logic                    busy,
  output logic                    error,
  output logic [1:0]              state_out
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned InW  = 4 * DIGITS;
  localparam int unsigned SumW = 4 * (DIGITS + 1);

  typedef enum logic [1:0] {StWaitA = 2'd0, StWaitB = 2'd1, StAdd = 2'd2, StDone = 2'd3} state_e;

  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic [InW-1:0]    opa_q, opa_d;
  logic [InW-1:0]    opb_q, opb_d;
  logic [SumW-1:0]   sum_q, sum_d;
  logic              sum_valid_q, sum_valid_d;
  logic              error_q, error_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;

  logic              event_w;
  logic              bad_w;
  logic              last_digit_w;

  function automatic logic has_bad_digit(input logic [InW-1:0] v);
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (v[4*i +: 4] > 4'd9) return 1'b1;
    end
    return 1'b0;
  endfunction

  assign event_w      = number_valid & ~valid_q;
  assign bad_w        = has_bad_digit(number_in);
  assign last_digit_w = (idx_q == IdxW'(DIGITS - 1));

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StWaitA;
      valid_q     <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      error_q     <= 1'b0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      error_q     <= error_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StWaitA;
    end else begin
      unique case (state_q)
        StWaitA: if (event_w && !bad_w) state_d = StWaitB;
        StWaitB: if (event_w && !bad_w) state_d = StAdd;
        StAdd:   if (last_digit_w) state_d = StDone;
        StDone:  if (event_w && !bad_w) state_d = StWaitB;
        default: state_d = StWaitA;
      endcase
    end
  end

  // Datapath next-state
  always_comb begin
    logic [3:0]  a_dig;
    logic [3:0]  b_dig;
    logic [4:0]  t;
    logic [4:0]  t_adj;
    logic [3:0]  s_dig;
    logic        c_out;
    int unsigned lsb;

    valid_d     = number_valid;  // edge register runs in every state, clear included
    opa_d       = opa_q;
    opb_d       = opb_q;
    sum_d       = sum_q;
    sum_valid_d = sum_valid_q;
    error_d     = error_q;
    idx_d       = idx_q;
    carry_d     = carry_q;

    lsb   = 4 * int'(idx_q);
    a_dig = opa_q[lsb +: 4];
    b_dig = opb_q[lsb +: 4];
    t     = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry_q};
    t_adj = t - 5'd10;
    if (t > 5'd9) begin
      s_dig = t_adj[3:0];
      c_out = 1'b1;
    end else begin
      s_dig = t[3:0];
      c_out = 1'b0;
    end

    if (clear) begin
      opa_d       = '0;
      opb_d       = '0;
      sum_d       = '0;
      sum_valid_d = 1'b0;
      error_d     = 1'b0;
      idx_d       = '0;
      carry_d     = 1'b0;
    end else begin
      unique case (state_q)
        StWaitA: begin
          if (event_w) begin
            error_d = bad_w;
            if (!bad_w) opa_d = number_in;
          end
        end
        StWaitB: begin
          if (event_w) begin
            error_d = bad_w;
            if (!bad_w) begin
              opb_d   = number_in;
              idx_d   = '0;
              carry_d = 1'b0;
              sum_d   = '0;
            end
          end
        end
        StAdd: begin
          // Events are ignored here; the edge register still tracks the level.
          sum_d[lsb +: 4] = s_dig;
          carry_d         = c_out;
          idx_d           = idx_q + 1'b1;
          if (last_digit_w) begin
            sum_d[4*DIGITS +: 4] = {3'b000, c_out};
            sum_valid_d          = 1'b1;
          end
        end
        StDone: begin
          if (event_w) begin
            error_d = bad_w;
            // A valid event starts a new operand A; the old sum stays visible.
            if (!bad_w) begin
              opa_d       = number_in;
              sum_valid_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs, all derived from registers only
  always_comb begin
    operand_a = opa_q;
    operand_b = opb_q;
    sum_bcd   = sum_q;
    sum_valid = sum_valid_q;
    error     = error_q;
    busy      = (state_q == StAdd);
    state_out = state_q;
  end

endmodule

// File: doc/bcd_operand_adder.md
Name: bcd_operand_adder

Overview:
- Sits directly downstream of the DIP-switch input manager; consumes its assembled 3-digit BCD number and its ready flag.
- Collects two successive numbers as operands A and B, then adds them in BCD, one digit per clock, ripple-carry.
- Result (0000–1998 BCD) plus status flags feed the display/LED stage.

Parameters:
DIGITS, 3, number of BCD digits per operand; input width 4*DIGITS, sum width 4*(DIGITS+1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
number_in  input  4*DIGITS  BCD operand from input manager; digit i at bits [4i+3:4i], most-significant digit at the top
number_valid  input  1  input manager ready; level signal, only its 0->1 transition is an event
clear  input  1  synchronous abort/restart, active-high
operand_a  output  4*DIGITS  captured operand A
operand_b  output  4*DIGITS  captured operand B
sum_bcd  output  4*(DIGITS+1)  BCD sum; top digit is 0 or 1
sum_valid  output  1  high while sum_bcd holds a completed result
busy  output  1  high during ADD state
error  output  1  sticky flag: last captured number contained a digit > 9
state_out  output  2  encoded state for LEDs: 0 WAIT_A, 1 WAIT_B, 2 ADD, 3 DONE

Behaviour:
- Reset (reset==0 at a clk edge): state WAIT_A; operand_a, operand_b, sum_bcd = 0; sum_valid, busy, error = 0; edge register = 0.
- Edge detect: register valid_q <= number_valid every cycle, including in ADD. Event = number_valid & ~valid_q.
  - A level held high yields exactly one event.
  - The edge register is cleared only by reset, not by clear.
- Validation: on each event, if any digit of number_in > 9:
  - set error and do not capture;
  - state is unchanged.
  - Otherwise clear error and capture per state.
- WAIT_A: valid event -> operand_a <= number_in; go WAIT_B.
- WAIT_B: valid event -> operand_b <= number_in; digit index <= 0; carry <= 0; go ADD.
- ADD: busy = 1. Each cycle:
  - t = a[i] + b[i] + carry (5-bit).
  - If t > 9: sum digit i = t − 10, carry = 1. Else: sum digit i = t, carry = 0.
  - i increments.
  - After digit DIGITS−1: top sum digit = carry (zero-extended); go DONE.
  - Events during ADD are ignored: not captured, not validated, error unchanged.
- Latency: B captured at edge k -> ADD occupies edges k+1..k+DIGITS -> sum_valid = 1 and state DONE visible after edge k+DIGITS (3 cycles at default).
- sum_bcd: cleared to 0 on entry to ADD; final value stable once sum_valid is high.
- DONE: sum_valid = 1 and is held.
  - A valid event is taken as a new operand A: operand_a captured, sum_valid <= 0, sum_bcd held, go WAIT_B.
  - An invalid event sets error and stays in DONE with sum_valid held.
- clear (reset inactive):
  - next state WAIT_A; operand_a, operand_b, sum_bcd = 0; sum_valid, busy, error = 0.
  - Allowed in any state, including mid-ADD (the partial sum is discarded).
  - clear has priority over a simultaneous event; that event is lost.
- Priority: reset > clear > event.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, then events with 0x123 then 0x456 -> state_out 1 after the first event; busy for 3 cycles; sum_bcd = 0x0579; sum_valid = 1 exactly 3 cycles after B capture.
- Operands 0x999 + 0x999 -> sum_bcd = 0x1998, sum_valid = 1; then 0x095 + 0x005 -> 0x0100 (carry ripples through two digits).
- Event with 0x1A3 in WAIT_A -> error = 1, state_out stays 0, operand_a unchanged; next event 0x200 -> error = 0, operand_a = 0x200, state_out = 1.
- number_valid held high for 20 cycles with 0x111 -> only operand_a captured, state_out stays 1; a new 0->1 transition with 0x222 -> sum 0x0333.
- clear asserted on the second ADD cycle of 0x500 + 0x600 -> next cycle state_out 0, busy 0, sum_bcd 0, sum_valid 0; a later event in the same cycle as clear is not captured.
- In DONE with sum 0x0579, event 0x010 -> sum_valid drops, operand_a = 0x010, sum_bcd still 0x0579 until B arrives; B = 0x020 -> 0x0030. Synchronous reset applied mid-ADD -> all outputs 0 at the next edge.
